// File: rtl/alu_pkg.sv
// Shared definitions for the bit-slice ALU family: opcode encoding, operand
// widths and the full-adder helper that both ADD and SUB are built on.
package alu_pkg;

    // Width of the opcode field carried on every slice's select input.
    localparam int unsigned ALU_OP_W = 3;

    // Opcode encoding shared by every slice in a chain.
    typedef enum logic [ALU_OP_W-1:0] {
        OP_AND      = 3'd0,
        OP_NOT      = 3'd1,
        OP_OR       = 3'd2,
        OP_XOR      = 3'd3,
        OP_ADD      = 3'd4,
        OP_SUB      = 3'd5,
        OP_TRANSFER = 3'd6,
        OP_TEST     = 3'd7
    } alu_op_t;

    // Result of one slice: the result bit and the carry/chain bit.
    typedef struct packed {
        logic carry;
        logic res;
    } alu_bit_res_t;

    // One-bit full adder. SUB reuses it by feeding in the inverted B operand,
    // so a chain with LSB carry-in of 1 forms A + ~B + 1 = A - B.
    function automatic alu_bit_res_t full_add(input logic x, input logic y, input logic cin);
        alu_bit_res_t r;
        r.res   = x ^ y ^ cin;
        r.carry = (x & y) | (x & cin) | (y & cin);
        return r;
    endfunction

endpackage : alu_pkg

// File: rtl/alu_bit_core.sv
// Purely combinational single-bit ALU function. Wider ALUs chain these
// directly (carry to carry) and register only at their own boundary.
module alu_bit_core
    import alu_pkg::*;
(
    input  logic                i_a,
    input  logic                i_b,
    input  logic                i_carry_in,
    input  logic [ALU_OP_W-1:0] i_select,
    output logic                o_out,
    output logic                o_carry_out
);

    alu_op_t      w_op;
    alu_bit_res_t w_add;
    alu_bit_res_t w_sub;
    logic         w_eq;

    assign w_op  = alu_op_t'(i_select);
    assign w_add = full_add(i_a, i_b, i_carry_in);
    assign w_sub = full_add(i_a, ~i_b, i_carry_in);
    assign w_eq  = ~(i_a ^ i_b);

    // Opcode decode: every path drives both outputs so unused operands
    // (b for NOT/TRANSFER, carry_in for the logic ops) never leak through.
    always_comb begin
        o_out       = 1'b0;
        o_carry_out = 1'b0;
        case (w_op)
            OP_AND:      o_out = i_a & i_b;
            OP_NOT:      o_out = ~i_a;
            OP_OR:       o_out = i_a | i_b;
            OP_XOR:      o_out = i_a ^ i_b;
            OP_ADD: begin
                o_out       = w_add.res;
                o_carry_out = w_add.carry;
            end
            OP_SUB: begin
                // carry_out = 1 means no borrow out of this bit.
                o_out       = w_sub.res;
                o_carry_out = w_sub.carry;
            end
            OP_TRANSFER: o_out = i_a;
            OP_TEST: begin
                // Equality chain: the carry stays high only while every
                // bit so far has matched.
                o_out       = w_eq;
                o_carry_out = i_carry_in & w_eq;
            end
            default: begin
                o_out       = 1'b0;
                o_carry_out = 1'b0;
            end
        endcase
    end

endmodule : alu_bit_core

// File: rtl/alu_bit_slice.sv
// Single-bit ALU slice with registered result and carry. The combinational
// function lives in alu_bit_core; this wrapper adds the output register,
// which clears asynchronously when rst_n goes low.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a,
    input  logic                b,
    input  logic                carry_in,
    input  logic [ALU_OP_W-1:0] select,
    output logic                out,
    output logic                carry_out
);

    logic w_out_p0;
    logic w_carry_p0;
    logic r_out_p1;
    logic r_carry_p1;

    alu_bit_core u_core (
        .i_a         (a),
        .i_b         (b),
        .i_carry_in  (carry_in),
        .i_select    (select),
        .o_out       (w_out_p0),
        .o_carry_out (w_carry_p0)
    );

    // Output register: captures the slice result every cycle; reset drops
    // both bits immediately and discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_p1   <= 1'b0;
            r_carry_p1 <= 1'b0;
        end else begin
            r_out_p1   <= w_out_p0;
            r_carry_p1 <= w_carry_p0;
        end
    end

    assign out       = r_out_p1;
    assign carry_out = r_carry_p1;

endmodule : alu_bit_slice

// File: tb/tb_alu_bit_slice.sv
// Directed bench for alu_bit_slice: reset, per-opcode truth tables,
// back-to-back opcode changes and mid-cycle asynchronous reset.
module tb_alu_bit_slice;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       carry_in;
    logic [2:0] select;
    logic       out;
    logic       carry_out;

    int n_cmp;
    int n_fail;

    // Hand-written truth tables, bit index = {a,b,carry_in}.
    logic [7:0] exp_out [8];
    logic [7:0] exp_co  [8];

    alu_bit_slice dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .select    (select),
        .out       (out),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs at the falling edge, then sample 1 unit after the rising edge.
    task automatic apply(input logic [2:0] op, input logic va, input logic vb, input logic vc);
        @(negedge clk);
        select   = op;
        a        = va;
        b        = vb;
        carry_in = vc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        a = 1'b1; b = 1'b1; carry_in = 1'b1; select = 3'd4;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({carry_out, out} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_immediate: got cout,out=%b%b want 00", carry_out, out);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({carry_out, out} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_held: got cout,out=%b%b want 00", carry_out, out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({carry_out, out} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release_add111: got cout,out=%b%b want 11", carry_out, out);
        end
    endtask

    task automatic sweep_op(input logic [2:0] op);
        logic [7:0] eo;
        logic [7:0] ec;
        eo = exp_out[op];
        ec = exp_co[op];
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            apply(op, v[2], v[1], v[0]);
            n_cmp++;
            if (out !== eo[i] || carry_out !== ec[i]) begin
                n_fail++;
                $display("FAIL op%0d abc=%b: got cout,out=%b%b want %b%b",
                         op, v, carry_out, out, ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_logic();
        sweep_op(3'd0);
        sweep_op(3'd1);
        sweep_op(3'd2);
        sweep_op(3'd3);
        sweep_op(3'd6);
    endtask

    task automatic test_add();
        sweep_op(3'd4);
    endtask

    task automatic test_sub();
        sweep_op(3'd5);
    endtask

    task automatic test_equal();
        sweep_op(3'd7);
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [6];
        logic [2:0] abc [6];
        logic [1:0] want [6];
        ops  = '{3'd4, 3'd0, 3'd5, 3'd7, 3'd1, 3'd2};
        abc  = '{3'b110, 3'b110, 3'b011, 3'b111, 3'b010, 3'b000};
        // ADD 1+1+0 -> c1 s0; AND 1&1 -> 01; SUB 0-1 w/ cin -> c0 s1;
        // TEST eq cin1 -> 11; NOT a=0 -> 01; OR 0|0 -> 00
        want = '{2'b10, 2'b01, 2'b01, 2'b11, 2'b01, 2'b00};
        for (int i = 0; i < 6; i++) begin
            logic [2:0] v;
            logic [1:0] w;
            v = abc[i];
            w = want[i];
            apply(ops[i], v[2], v[1], v[0]);
            n_cmp++;
            if ({carry_out, out} !== w) begin
                n_fail++;
                $display("FAIL b2b step%0d op%0d: got cout,out=%b%b want %b",
                         i, ops[i], carry_out, out, w);
            end
        end
        // Mid-cycle async reset with a result of 11 in the register.
        apply(3'd4, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if ({carry_out, out} !== 2'b11) begin
            n_fail++;
            $display("FAIL midrst_pre: got cout,out=%b%b want 11", carry_out, out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({carry_out, out} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_drop: got cout,out=%b%b want 00", carry_out, out);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({carry_out, out} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_hold: got cout,out=%b%b want 00", carry_out, out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(3'd6, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({carry_out, out} !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_resume_transfer: got cout,out=%b%b want 01", carry_out, out);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        exp_out[0] = 8'b1100_0000; exp_co[0] = 8'b0000_0000; // AND
        exp_out[1] = 8'b0000_1111; exp_co[1] = 8'b0000_0000; // NOT
        exp_out[2] = 8'b1111_1100; exp_co[2] = 8'b0000_0000; // OR
        exp_out[3] = 8'b0011_1100; exp_co[3] = 8'b0000_0000; // XOR
        exp_out[4] = 8'b1001_0110; exp_co[4] = 8'b1110_1000; // ADD
        exp_out[5] = 8'b0110_1001; exp_co[5] = 8'b1011_0010; // SUB
        exp_out[6] = 8'b1111_0000; exp_co[6] = 8'b0000_0000; // TRANSFER
        exp_out[7] = 8'b1100_0011; exp_co[7] = 8'b1000_0010; // TEST
        rst_n = 1'b1;
        a = 1'b0; b = 1'b0; carry_in = 1'b0; select = 3'd0;

        test_reset();
        test_logic();
        test_add();
        test_sub();
        test_equal();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_alu_bit_slice

// File: doc/alu_bit_slice.md
Name: alu_bit_slice

Overview:
Single-bit ALU slice with registered outputs. It is intended to be chained bit-wise, carry to carry, into wider ALUs such as the 4-bit ALU. It performs one of eight logic or arithmetic operations on operands a and b, selected by a 3-bit opcode. Result and carry-out are captured on the clock edge.

Parameters:
None. Opcode encodings are fixed constants held in the shared package.

Ports:
clk        input   1  system clock; rising-edge active
rst_n      input   1  asynchronous, active-low reset
a          input   1  operand A
b          input   1  operand B
carry_in   input   1  carry in for ADD/SUB; chain-in for TEST
select     input   3  opcode; see Behaviour
out        output  1  registered result bit
carry_out  output  1  registered carry/chain output

Behaviour:
- Reset:
  - rst_n low clears out=0 and carry_out=0 immediately, without waiting for a clock edge.
  - Outputs hold 0 while rst_n is low.
  - First capture occurs on the first rising clk after rst_n deasserts.
- Latency:
  - Inputs sampled at rising clk appear on out/carry_out after that edge, i.e. 1-cycle latency.
  - Registers update every cycle. There is no enable and no handshake.
- Function computed combinationally from a, b, carry_in and select, then registered:
  - 0 AND: out=a&b; carry_out=0
  - 1 NOT: out=~a (b ignored); carry_out=0
  - 2 OR: out=a|b; carry_out=0
  - 3 XOR: out=a^b; carry_out=0
  - 4 ADD: {carry_out,out} = a+b+carry_in (full adder)
  - 5 SUB: {carry_out,out} = a+(~b)+carry_in. This is two's-complement subtract. A chain computes A−B when the LSB carry_in=1. carry_out=1 means no borrow.
  - 6 TRANSFER: out=a; carry_out=0
  - 7 TEST (equality): out=~(a^b); carry_out=carry_in & ~(a^b). Chaining with LSB carry_in=1 gives MSB carry_out=1 iff A==B.
- carry_in is ignored for opcodes 0–3 and 6.
- Outputs are fully determined by the sampled inputs. No X propagation from unused inputs.
- Reset asserted mid-operation:
  - Outputs are forced to 0 asynchronously.
  - The in-flight result is discarded.
- Opcode changes take effect on the next edge, with no stale-state dependence.

Decomposition:
- Shared package alu_pkg holds:
  - typedef alu_op_t, a 3-bit enum: OP_AND=0, OP_NOT=1, OP_OR=2, OP_XOR=3, OP_ADD=4, OP_SUB=5, OP_TRANSFER=6, OP_TEST=7.
  - The op-width constant, 3.
- One natural sub-module, alu_bit_core: purely combinational function of (a, b, carry_in, select) giving (out, carry_out). The top wraps it with the async-reset output register.
- Wider ALUs reuse alu_bit_core directly for ripple chaining, registering only at their own boundary.

Test Plan:
- Reset: drive rst_n=0 with a=1, b=1, select=ADD, carry_in=1 → out=0, carry_out=0 immediately and held across clocks. Release reset → the next edge gives out=1, carry_out=1.
- Logic ops: sweep all 8 (a,b,carry_in) combos for AND/NOT/OR/XOR/TRANSFER. For example a=1, b=0 gives AND→0, OR→1, XOR→1, NOT→0, TRANSFER→1. carry_out=0 in every case, and carry_in has no effect.
- ADD exhaustive: a=1,b=1,cin=0 → out=0,cout=1; a=1,b=0,cin=1 → out=0,cout=1; a=0,b=0,cin=1 → out=1,cout=0. All 8 combos must match the full-adder sum/carry.
- SUB: a=1,b=0,cin=1 → out=1,cout=1. a=0,b=1,cin=1 → out=1,cout=0 (borrow). a=1,b=1,cin=1 → out=0,cout=1.
- TEST: a=b=1,cin=1 → out=1,cout=1. a=1,b=0,cin=1 → out=0,cout=0. a=b=0,cin=0 → out=1,cout=0.
- Latency and async reset: change select every cycle. Check each output corresponds to the inputs of the previous edge. Assert rst_n between edges and check outputs drop to 0 before the next clk.
